execute_muldiv: RTL
===================

Name: execute_muldiv

Overview:
Parametrised multi-cycle execute unit for the RV32M extension. It sits beside the single-cycle ALU/CMP path in the EX stage and accepts one renamed M-type operation at a time over a valid/ready handshake. Multiplies go through a pipelined multiplier of configurable depth; divides and remainders run on an iterative radix-2 divider. The result returns tagged with the destination physical register so the pipeline can write back and forward it. Supports flush of the in-flight operation on branch/jump mispredict.

Parameters:
XLEN, 32, operand/result width in bits (even, >=8)
TAG_W, 6, width of destination physical-register tag
MUL_STAGES, 3, multiplier latency in cycles (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operation offered
in_ready  output  1  unit can accept (high only in IDLE)
in_op  input  3  funct3 of the M instruction (muldiv_op_t)
in_a  input  XLEN  rs1 value (already forwarded)
in_b  input  XLEN  rs2 value (already forwarded)
in_tag  input  TAG_W  dest_phys_new of the instruction
flush  input  1  kill in-flight/pending operation
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_result  output  XLEN  result value
out_tag  output  TAG_W  tag captured at accept

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE, in_ready=1 once rst deasserts, out_valid=0, out_result=0, out_tag=0, counters=0. Reset asserted mid-operation discards the operation with no output.
- Accept: in_valid&&in_ready&&!flush at edge t captures op, operands, tag.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE -> MUL for op[2]=0. IDLE -> DIV for op[2]=1 normal case. IDLE -> DONE for div special cases.
- MUL -> DONE after MUL_STAGES cycles. DIV -> DONE after XLEN iterations. DONE -> IDLE on out_ready.
- Mul ops: 000 MUL = low XLEN of product; 001 MULH = high XLEN signed*signed; 010 MULHSU = high, signed a * unsigned b; 011 MULHU = high unsigned*unsigned.
- Mul implementation: extend operands to XLEN+1 bits per signedness and form a 2*XLEN+2 product.
- Mul latency: out_valid first high in cycle t+MUL_STAGES.
- Div ops: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Signed ops divide magnitudes.
- Div sign fix: quotient negated iff operand signs differ; remainder takes dividend sign.
- Div latency: XLEN iterations, one quotient bit per cycle; out_valid first high in cycle t+XLEN+1.
- Divide by zero: quotient=all ones, remainder=dividend; out_valid at t+1.
- Signed overflow (a=MIN, b=-1): DIV=MIN, REM=0; out_valid at t+1.
- DONE: out_valid=1; out_result/out_tag stable until handshake. Return to IDLE on out_ready; in_ready rises the cycle after. No accept in the same cycle as result handoff.
- Flush: takes priority over everything except rst. Any state -> IDLE at next edge.
- Flush output gating: out_valid gated low combinationally in the flush cycle. An in_valid in the flush cycle is ignored.
- MUL_STAGES=1 boundary: result at t+1, identical to the div special-case timing.
- in_ready is registered-state-derived only: no combinational path from in_valid.

Decomposition:
- In the shared rv32i_types package: muldiv_op_t enum (the 8 funct3 encodings above).
- In the shared package: localparam constants for the div-by-zero quotient and the MIN value, derived from XLEN.
- One natural sub-module, mul_pipe: parametrised by XLEN and MUL_STAGES. It takes signed-extended operands and a valid bit and shifts the product through MUL_STAGES registers, with a flush-clear on valid bits.
- The divider and FSM stay in execute_muldiv.

Test Plan:
- MUL 7 * -3 (0x00000007, 0xFFFFFFFD), tag 5, MUL_STAGES=3 -> out_valid at t+3, result 0xFFFFFFEB, tag 5. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD at t+33. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at t+1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> out_valid, result and tag stable. in_ready=0 throughout. in_ready=1 the cycle after the handshake.
- Flush at cycle t+10 of a DIV -> out_valid never rises. in_ready=1 next cycle. A following MUL 3*4 returns 12 with its own tag.
- Assert rst asynchronously mid-MUL -> outputs zero immediately. No stale result after release. A new op completes correctly.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types: M-extension funct3 encodings, muldiv FSM
// states and the architectural divide constants for the base XLEN.
package rv32i_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } muldiv_state_t;

  localparam int unsigned         RV_XLEN    = 32;
  localparam logic [RV_XLEN-1:0]  DIV_ZERO_Q = '1;
  localparam logic [RV_XLEN-1:0]  XLEN_MIN   = {1'b1, {(RV_XLEN-1){1'b0}}};

endpackage

// File: rtl/mul_pipe.sv
// Pipelined signed (XLEN+1)x(XLEN+1) multiplier; the product is formed on
// the way in and shifted through MUL_STAGES registers.
module mul_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic signed [XLEN:0]   in_a,
  input  logic signed [XLEN:0]   in_b,
  output logic                   out_valid,
  output logic [2*XLEN+1:0]      out_prod
);

  logic signed [2*XLEN+1:0] prod;
  logic [MUL_STAGES-1:0]    vld_q, vld_d;
  logic [2*XLEN+1:0]        stage_q [MUL_STAGES];
  logic [2*XLEN+1:0]        stage_d [MUL_STAGES];

  assign prod = in_a * in_b;

  // Data only advances behind a valid bit so an idle pipe holds its last value
  always_comb begin
    vld_d[0]   = in_valid && !flush;
    stage_d[0] = in_valid ? prod : stage_q[0];
    for (int unsigned i = 1; i < MUL_STAGES; i++) begin
      vld_d[i]   = vld_q[i-1] && !flush;
      stage_d[i] = vld_q[i-1] ? stage_q[i-1] : stage_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < MUL_STAGES; i++) stage_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      stage_q <= stage_d;
    end
  end

  assign out_valid = vld_q[MUL_STAGES-1];
  assign out_prod  = stage_q[MUL_STAGES-1];

endmodule

// File: rtl/execute_muldiv.sv
// RV32M execute unit: pipelined multiplier plus iterative radix-2 restoring
// divider, one operation in flight, result returned with its physical tag.
module execute_muldiv
  import rv32i_types::*;
#(
  parameter int unsigned XLEN       = RV_XLEN,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned MUL_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  muldiv_op_t       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned     CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [XLEN-1:0]  result_q, result_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic              accept, in_signed, a_sgn, b_sgn, mul_in_valid, mul_valid;
  logic [XLEN:0]     mul_a, mul_b, trial, diff;
  logic [2*XLEN+1:0] mul_prod;
  logic [XLEN-1:0]   mul_sel, mag_a, mag_b, rem_nx, quo_nx;
  logic              unused_prod_msbs;

  assign in_ready     = (state_q == S_IDLE);
  assign accept       = in_valid && in_ready && !flush;
  assign a_sgn        = (in_op != OP_MULHU);
  assign b_sgn        = (in_op == OP_MUL) || (in_op == OP_MULH);
  assign mul_a        = {a_sgn & in_a[XLEN-1], in_a};
  assign mul_b        = {b_sgn & in_b[XLEN-1], in_b};
  assign mul_in_valid = accept && !in_op[2];

  mul_pipe #(
    .XLEN       (XLEN),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (mul_in_valid),
    .in_a      (mul_a),
    .in_b      (mul_b),
    .out_valid (mul_valid),
    .out_prod  (mul_prod)
  );

  assign mul_sel          = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  assign unused_prod_msbs = ^mul_prod[2*XLEN+1:2*XLEN];

  // Restoring step: the borrow out of the trial subtraction is the inverted quotient bit
  assign in_signed = !in_op[0];
  assign mag_a     = (in_signed && in_a[XLEN-1]) ? -in_a : in_a;
  assign mag_b     = (in_signed && in_b[XLEN-1]) ? -in_b : in_b;
  assign trial     = {rem_q, quo_q[XLEN-1]};
  assign diff      = trial - {1'b0, dvs_q};
  assign rem_nx    = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nx    = {quo_q[XLEN-2:0], ~diff[XLEN]};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    tag_d    = tag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = in_op;
          tag_d = in_tag;
          if (!in_op[2]) begin
            state_d = S_MUL;
          end else if (in_b == '0) begin
            result_d = in_op[1] ? in_a : '1;
            state_d  = S_DONE;
          end else if (in_signed && (in_a == MIN_VAL) && (in_b == '1)) begin
            result_d = in_op[1] ? '0 : MIN_VAL;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            cnt_d   = '0;
            q_neg_d = in_signed && (in_a[XLEN-1] ^ in_b[XLEN-1]);
            r_neg_d = in_signed && in_a[XLEN-1];
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (mul_valid) begin
          result_d = mul_sel;
          state_d  = out_ready ? S_IDLE : S_DONE;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          result_d = op_q[1] ? (r_neg_q ? -rem_nx : rem_nx)
                             : (q_neg_q ? -quo_nx : quo_nx);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      result_q <= '0;
      tag_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  // A finished product is presented straight from the pipe, then held in result_q
  assign out_valid  = !flush && ((state_q == S_DONE) || ((state_q == S_MUL) && mul_valid));
  assign out_result = ((state_q == S_MUL) && mul_valid) ? mul_sel : result_q;
  assign out_tag    = tag_q;

endmodule
